ps2_scancode_decoder: RTL

- Downstream consumer of the PS/2 byte receiver. Takes each received byte (dout, rx_done_tick) and strips the scan-code-set-2 prefixes: E0 (extended), F0 (break) and the E1 Pause sequence.
- Tracks the Shift and Ctrl modifiers and produces key events. Each event carries code, ext, release, and ASCII for the printable subset.
- Events are buffered in a small FIFO for the application logic. When the FIFO is full, the block throttles the receiver through rx_en.

---
 rtl/ps2_scancode_decoder_if.sv | 30 +++
 rtl/ps2_scancode_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-stream and key-event bundle between the PS/2 receiver, the scan-code
// decoder and the application logic.
interface ps2_scancode_decoder_if;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       rx_en;
   logic       ev_rd;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_release;
   logic [7:0] ev_ascii;
   logic       shift_held;
   logic       ctrl_held;
   logic       overflow;

   // Decoder side: consumes receiver bytes and pop requests, presents events.
   modport master (
      input  rx_done_tick, rx_data, ev_rd,
      output rx_en, ev_valid, ev_code, ev_ext, ev_release, ev_ascii,
             shift_held, ctrl_held, overflow
   );

   // Environment side: receiver plus application logic.
   modport slave (
      output rx_done_tick, rx_data, ev_rd,
      input  rx_en, ev_valid, ev_code, ev_ext, ev_release, ev_ascii,
             shift_held, ctrl_held, overflow
   );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Scan-code-set-2 prefix stripper with Shift/Ctrl tracking, ASCII mapping of
// make events, and a small event FIFO that throttles the receiver when full.
module ps2_scancode_decoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   ps2_scancode_decoder_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PFX   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam int               ENTRY_W = 18;

   // Receiver housekeeping bytes that carry no key information.
   function automatic logic is_discard(input logic [7:0] b);
      logic r;
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA,
         8'hFC, 8'hFD, 8'hFE, 8'hFF: r = 1'b1;
         default:                    r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] ascii_lut(input logic [7:0] code, input logic shift);
      logic [7:0] lc;
      logic       letter;
      lc     = 8'h00;
      letter = 1'b1;
      case (code)
         8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;
         8'h23: lc = 8'h64;  8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;
         8'h34: lc = 8'h67;  8'h33: lc = 8'h68;  8'h43: lc = 8'h69;
         8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
         8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;
         8'h4D: lc = 8'h70;  8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;
         8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;  8'h3C: lc = 8'h75;
         8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
         8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
         default: letter = 1'b0;
      endcase
      if (letter) begin
         return shift ? (lc - 8'h20) : lc;
      end
      case (code)
         8'h45: lc = shift ? 8'h29 : 8'h30;
         8'h16: lc = shift ? 8'h21 : 8'h31;
         8'h1E: lc = shift ? 8'h40 : 8'h32;
         8'h26: lc = shift ? 8'h23 : 8'h33;
         8'h25: lc = shift ? 8'h24 : 8'h34;
         8'h2E: lc = shift ? 8'h25 : 8'h35;
         8'h36: lc = shift ? 8'h5E : 8'h36;
         8'h3D: lc = shift ? 8'h26 : 8'h37;
         8'h3E: lc = shift ? 8'h2A : 8'h38;
         8'h46: lc = shift ? 8'h28 : 8'h39;
         8'h29: lc = 8'h20;
         8'h5A: lc = 8'h0D;
         8'h66: lc = 8'h08;
         default: lc = 8'h00;
      endcase
      return lc;
   endfunction

   state_t               state_q, state_d;
   logic                 ext_q, ext_d, brk_q, brk_d;
   logic [2:0]           pause_q, pause_d;
   logic                 shift_l_q, shift_l_d, shift_r_q, shift_r_d;
   logic                 ctrl_q, ctrl_d, ovf_q, ovf_d;
   logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]       count_q, count_d;

   logic                 emit_s, em_ext_s, em_rel_s;
   logic [7:0]           em_code_s, em_ascii_s;
   logic                 shift_held_s, full_s, empty_s, pop_s, push_ok_s, drop_s;
   logic [ENTRY_W-1:0]   head_s;

   assign shift_held_s = shift_l_q | shift_r_q;

   // Prefix FSM next-state and event formation.
   always_comb begin
      state_d    = state_q;
      ext_d      = ext_q;
      brk_d      = brk_q;
      pause_d    = pause_q;
      emit_s     = 1'b0;
      em_code_s  = bus.rx_data;
      em_ext_s   = ext_q;
      em_rel_s   = brk_q;
      em_ascii_s = 8'h00;
      if (bus.rx_done_tick) begin
         case (state_q)
            S_IDLE, S_PFX: begin
               if (bus.rx_data == 8'hE0) begin
                  ext_d   = 1'b1;
                  state_d = S_PFX;
               end else if (bus.rx_data == 8'hF0) begin
                  brk_d   = 1'b1;
                  state_d = S_PFX;
               end else if ((state_q == S_IDLE) && (bus.rx_data == 8'hE1)) begin
                  pause_d = 3'd7;
                  state_d = S_PAUSE;
               end else if ((state_q == S_IDLE) && is_discard(bus.rx_data)) begin
                  state_d = state_q;
               end else begin
                  emit_s     = 1'b1;
                  em_ascii_s = (!ext_q && !brk_q) ? ascii_lut(bus.rx_data, shift_held_s) : 8'h00;
                  ext_d      = 1'b0;
                  brk_d      = 1'b0;
                  state_d    = S_IDLE;
               end
            end
            S_PAUSE: begin
               // Pause body bytes are consumed blindly; only their count matters.
               pause_d = pause_q - 3'd1;
               if (pause_q == 3'd1) begin
                  emit_s    = 1'b1;
                  em_code_s = 8'hE1;
                  em_ext_s  = 1'b0;
                  em_rel_s  = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  state_d = S_PAUSE;
               end
            end
            default: begin
               state_d = S_IDLE;
               ext_d   = 1'b0;
               brk_d   = 1'b0;
               pause_d = 3'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Modifier tracking on emitted events.
   always_comb begin
      shift_l_d = shift_l_q;
      shift_r_d = shift_r_q;
      ctrl_d    = ctrl_q;
      if (emit_s && !em_ext_s && (em_code_s == 8'h12)) begin
         shift_l_d = ~em_rel_s;
      end else if (emit_s && !em_ext_s && (em_code_s == 8'h59)) begin
         shift_r_d = ~em_rel_s;
      end else if (emit_s && (em_code_s == 8'h14)) begin
         ctrl_d = ~em_rel_s;
      end else begin
         shift_l_d = shift_l_q;
      end
   end

   assign full_s    = (count_q == DEPTH_C);
   assign empty_s   = (count_q == '0);
   assign pop_s     = bus.ev_rd && !empty_s;
   assign push_ok_s = emit_s && (!full_s || pop_s);
   assign drop_s    = emit_s && full_s && !pop_s;

   // FIFO pointer, occupancy and overflow next-state.
   always_comb begin
      wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      ovf_d    = ovf_q | drop_s;
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         pause_q   <= 3'd0;
         shift_l_q <= 1'b0;
         shift_r_q <= 1'b0;
         ctrl_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         ext_q     <= ext_d;
         brk_q     <= brk_d;
         pause_q   <= pause_d;
         shift_l_q <= shift_l_d;
         shift_r_q <= shift_r_d;
         ctrl_q    <= ctrl_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Event storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok_s) begin
         mem_q[wr_ptr_q] <= {em_code_s, em_ext_s, em_rel_s, em_ascii_s};
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   assign head_s         = empty_s ? '0 : mem_q[rd_ptr_q];
   assign bus.ev_valid   = !empty_s;
   assign bus.ev_code    = head_s[17:10];
   assign bus.ev_ext     = head_s[9];
   assign bus.ev_release = head_s[8];
   assign bus.ev_ascii   = head_s[7:0];
   assign bus.rx_en      = !full_s;
   assign bus.shift_held = shift_held_s;
   assign bus.ctrl_held  = ctrl_q;
   assign bus.overflow   = ovf_q;

endmodule
